// File: rtl/ps2_key_decoder_pkg.sv
// rtl/ps2_key_decoder_pkg.sv - shared constants and helpers for the PS/2 key decoder
package ps2_key_decoder_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] ASC_NONE = 8'h00;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  // PS/2 uses odd parity over the 8 data bits plus the parity bit
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_key_decoder_scan2ascii.sv
// rtl/ps2_key_decoder_scan2ascii.sv - set-2 make code to lowercase ASCII lookup ROM
module ps2_scan2ascii
  import ps2_key_decoder_pkg::*;
(
  input  logic [7:0] scan,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASC_NONE;
    case (scan)
      8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;  8'h5A: ascii = 8'h0D;  8'h66: ascii = 8'h08;
      8'h76: ascii = 8'h1B;
      default: ascii = ASC_NONE;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 frame receiver, make-code decoder and key-event FIFO
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rd_ready,
  output logic       key_valid,
  output logic [7:0] key_ascii,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic          clk_s1, clk_s2, clk_s3, dat_s1, dat_s2;
  logic          sample;
  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          byte_done;
  logic          brk, ext;
  logic [7:0]    rom_ascii;
  logic          push, pop, full, wr_en;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clkin) begin
    if (rst) begin
      {clk_s1, clk_s2, clk_s3, dat_s1, dat_s2} <= 5'b11111;
    end else begin
      {clk_s3, clk_s2, clk_s1} <= {clk_s2, clk_s1, ps2_clk};
      {dat_s2, dat_s1}         <= {dat_s1, ps2_dat};
    end
  end

  assign sample = clk_s3 & ~clk_s2;

  // Frame receiver; the timeout only runs mid-frame and restarts on every clock edge
  always_ff @(posedge clkin) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      tcnt      <= '0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      if (sample) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= dat_s2;
            state   <= STOP;
          end
          default: begin
            if (dat_s2 && odd_parity_ok(shreg, par_bit)) byte_done <= 1'b1;
            else                                          frame_err <= 1'b1;
            state <= IDLE;
          end
        endcase
      end else if (state != IDLE) begin
        if (tcnt == TMAX) begin
          frame_err <= 1'b1;
          state     <= IDLE;
          tcnt      <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

  // shreg stays stable from the STOP sample until the next frame's data bits
  ps2_scan2ascii u_rom (
    .scan  (shreg),
    .ascii (rom_ascii)
  );

  always_ff @(posedge clkin) begin
    if (rst) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (byte_done) begin
      if (shreg == SC_EXT)        ext <= 1'b1;
      else if (shreg == SC_BREAK) brk <= 1'b1;
      else if (brk) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (ext) begin
        ext <= 1'b0;
      end
    end
  end

  assign push = byte_done && (shreg != SC_EXT) && (shreg != SC_BREAK)
                && !brk && !ext && (rom_ascii != ASC_NONE);

  assign key_valid = (count != '0);
  assign full      = (count == FULL_CNT);
  assign pop       = rd_ready && key_valid;
  assign wr_en     = push && (!full || pop);
  assign key_ascii = key_valid ? mem[rd_ptr] : ASC_NONE;

  always_ff @(posedge clkin) begin
    if (wr_en) mem[wr_ptr] <= rom_ascii;
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - randomized PS/2 key decoder bench against a queue-based reference
module tb_ps2_key_decoder;

  localparam int DEPTH = 8;
  localparam int TMO   = 300;
  localparam int HALF  = 12;

  logic       clkin = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1, rd_ready = 1'b0;
  logic       key_valid, frame_err, overflow;
  logic [7:0] key_ascii;

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clkin(clkin), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .rd_ready(rd_ready),
    .key_valid(key_valid), .key_ascii(key_ascii), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clkin = ~clkin;

  int n_vec = 0, n_bad = 0, err_seen = 0, err_exp = 0;
  logic [7:0] q[$];
  bit m_brk = 0, m_ext = 0, m_ovf = 0;

  logic [7:0] let_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                              8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                              8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dig_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] oth_sc [4]  = '{8'h29, 8'h5A, 8'h66, 8'h76};
  logic [7:0] oth_as [4]  = '{8'h20, 8'h0D, 8'h08, 8'h1B};

  always @(negedge clkin) if (frame_err) err_seen++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] sc);
    for (int i = 0; i < 26; i++) if (let_sc[i] == sc) return 8'(8'h61 + i);
    for (int i = 0; i < 10; i++) if (dig_sc[i] == sc) return 8'(8'h30 + i);
    for (int i = 0; i < 4; i++)  if (oth_sc[i] == sc) return oth_as[i];
    return 8'h00;
  endfunction

  function automatic logic [7:0] rand_key();
    int k = $urandom_range(0, 39);
    if (k < 26) return let_sc[k];
    if (k < 36) return dig_sc[k-26];
    return oth_sc[k-36];
  endfunction

  task automatic model_byte(input logic [7:0] sc);
    logic [7:0] a;
    if (sc == 8'hE0) m_ext = 1;
    else if (sc == 8'hF0) m_brk = 1;
    else if (m_brk) begin m_brk = 0; m_ext = 0; end
    else if (m_ext) m_ext = 0;
    else begin
      a = ref_ascii(sc);
      if (a != 8'h00) begin
        if (q.size() == DEPTH) m_ovf = 1;
        else q.push_back(a);
      end
    end
  endtask

  // pop_sync raises rd_ready for exactly the cycle the decoded event is pushed
  task automatic ps2_bit(input logic b, input bit pop_sync = 0);
    @(negedge clkin);
    ps2_dat = b;
    repeat (HALF) @(negedge clkin);
    ps2_clk = 1'b0;
    if (pop_sync) begin
      repeat (3) @(negedge clkin);
      check_eq("pop_sync.head", key_ascii, (q.size() > 0) ? q[0] : 8'h00);
      rd_ready = 1'b1;
      @(negedge clkin);
      rd_ready = 1'b0;
      repeat (HALF - 4) @(negedge clkin);
    end else begin
      repeat (HALF) @(negedge clkin);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit flip_par = 0, input bit stop = 1,
                            input bit pop_sync = 0);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(~^code ^ flip_par);
    ps2_bit(stop, pop_sync);
    ps2_dat = 1'b1;
    repeat (4) @(negedge clkin);
    if (!flip_par && stop) begin
      if (pop_sync && q.size() > 0) void'(q.pop_front());
      model_byte(code);
    end else begin
      err_exp++;
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".valid"}, key_valid, q.size() != 0);
    check_eq({tag, ".ascii"}, key_ascii, (q.size() != 0) ? q[0] : 8'h00);
    check_eq({tag, ".ovf"}, overflow, m_ovf);
    check_eq({tag, ".errs"}, err_seen, err_exp);
  endtask

  task automatic drain(input int n);
    while (n > 0 && q.size() > 0) begin
      check_eq("drain.valid", key_valid, 1);
      check_eq("drain.ascii", key_ascii, q[0]);
      rd_ready = 1'b1;
      @(negedge clkin);
      rd_ready = 1'b0;
      void'(q.pop_front());
      n--;
    end
  endtask

  task automatic do_reset();
    @(negedge clkin);
    rst = 1'b1;
    repeat (3) @(negedge clkin);
    rst = 1'b0;
    q.delete();
    m_brk = 0; m_ext = 0; m_ovf = 0;
  endtask

  initial begin
    repeat (3) @(negedge clkin);
    check_eq("reset.valid", key_valid, 0);
    check_eq("reset.ascii", key_ascii, 0);
    check_eq("reset.err", frame_err, 0);
    check_eq("reset.ovf", overflow, 0);
    rst = 1'b0;
    repeat (3) @(negedge clkin);

    send_frame(8'h1C);
    check_state("make_a");
    drain(8);
    send_frame(8'h1C); send_frame(8'hF0); send_frame(8'h1C);
    check_state("make_break");
    drain(8);
    check_state("make_break.empty");
    send_frame(8'hE0); send_frame(8'h75); send_frame(8'h16);
    check_state("ext_then_1");
    drain(8);
    send_frame(8'h24, 1, 1);
    check_state("bad_parity");
    send_frame(8'h24, 0, 0);
    check_state("bad_stop");
    ps2_bit(1'b1);
    repeat (4) @(negedge clkin);
    err_exp++;
    check_state("bad_start");

    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1));
    repeat (TMO + 20) @(negedge clkin);
    err_exp++;
    check_state("timeout");
    send_frame(8'h2D);
    check_state("after_timeout");
    drain(8);

    for (int i = 0; i < 9; i++) send_frame(let_sc[i]);
    check_state("overflow");
    drain(8);
    check_state("overflow.empty");

    do_reset();
    for (int i = 0; i < 8; i++) send_frame(let_sc[i]);
    send_frame(let_sc[9], 0, 1, 1);
    check_state("full_push_pop");
    drain(8);

    rd_ready = 1'b1;
    repeat (3) @(negedge clkin);
    rd_ready = 1'b0;
    check_state("pop_empty");

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: send_frame(rand_key());
        4: send_frame(8'($urandom));
        5: begin send_frame(8'hF0); send_frame(rand_key()); end
        6: begin send_frame(8'hE0); send_frame(8'($urandom)); end
        7: send_frame(8'($urandom), 1, 1);
        8: send_frame(8'($urandom), 0, 0);
        default: begin
          ps2_bit(1'b1);
          repeat (4) @(negedge clkin);
          err_exp++;
        end
      endcase
      check_state("random");
      if ($urandom_range(0, 3) == 0) drain($urandom_range(1, 4));
    end

    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    do_reset();
    repeat (2 * TMO) @(negedge clkin);
    check_state("mid_frame_reset");
    send_frame(8'h1C);
    check_state("after_reset");
    drain(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
